// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data cache memory-port arbiter.
package mem_arb_pkg;

  // Arbiter state encoding
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IC = 2'd1,
    GRANT_DC = 2'd2
  } state_t;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Memory direction encoding on *_Read_Write_n
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // Last_Grant encoding: which requester won the previous burst
  localparam logic LAST_WAS_IC = 1'b0;
  localparam logic LAST_WAS_DC = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker; requester A is the icache, B the dcache.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_update,
  output logic o_pick_a_c,
  output logic o_pick_b_c
);

  logic last_grant_q;
  logic last_grant_d;

  // On contention favour whoever did not win last time
  always_comb begin
    o_pick_a_c = i_req_a & (~i_req_b | (last_grant_q == LAST_WAS_DC));
    o_pick_b_c = i_req_b & ~o_pick_a_c;
  end

  // Record the winner only when the caller commits a grant
  always_comb begin
    last_grant_d = last_grant_q;
    if (i_update && o_pick_a_c) begin
      last_grant_d = LAST_WAS_IC;
    end else if (i_update && o_pick_b_c) begin
      last_grant_d = LAST_WAS_DC;
    end
  end

  // Last_Grant register; resets to DC so the icache wins the first tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= LAST_WAS_DC;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory burst port between the icache and the dcache.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 21,
  parameter int unsigned BURST_LEN     = 4,
  parameter int unsigned COUNT_WIDTH   = 3
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,

  input  logic                     i_IC_MEM_Valid,
  input  logic [ADDRESS_WIDTH-1:0] i_IC_MEM_Address,
  output logic                     o_IC_MEM_Valid,
  output logic                     o_IC_MEM_Last,
  output logic [DATA_WIDTH-1:0]    o_IC_MEM_Data,

  input  logic                     i_DC_MEM_Valid,
  input  logic                     i_DC_MEM_Read_Write_n,
  input  logic [ADDRESS_WIDTH-1:0] i_DC_MEM_Address,
  input  logic [DATA_WIDTH-1:0]    i_DC_MEM_Data,
  output logic                     o_DC_MEM_Valid,
  output logic                     o_DC_MEM_Last,
  output logic [DATA_WIDTH-1:0]    o_DC_MEM_Data,

  output logic                     o_MEM_Valid,
  output logic                     o_MEM_Read_Write_n,
  output logic [ADDRESS_WIDTH-1:0] o_MEM_Address,
  output logic [DATA_WIDTH-1:0]    o_MEM_Data,
  input  logic                     i_MEM_Valid,
  input  logic                     i_MEM_Last,
  input  logic [DATA_WIDTH-1:0]    i_MEM_Data,

  output logic                     o_Protocol_Error
);

  localparam logic [COUNT_WIDTH-1:0] LAST_BEAT = COUNT_WIDTH'(BURST_LEN - 1);

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                   error_q, error_d;
  logic                   pick_ic_c, pick_dc_c;
  logic                   arb_update_c;

  // Round-robin choice is only committed while idle
  assign arb_update_c = (state_q == IDLE);

  rr_arbiter2 u_rr (
    .clk        (i_Clk),
    .rst_n      (i_Reset_n),
    .i_req_a    (i_IC_MEM_Valid),
    .i_req_b    (i_DC_MEM_Valid),
    .i_update   (arb_update_c),
    .o_pick_a_c (pick_ic_c),
    .o_pick_b_c (pick_dc_c)
  );

  // Next-state: grant from idle, count beats, release on Last or overrun
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    error_d    = error_q;
    unique case (state_q)
      IDLE: begin
        if (pick_ic_c) begin
          state_d    = GRANT_IC;
          beat_cnt_d = '0;
        end else if (pick_dc_c) begin
          state_d    = GRANT_DC;
          beat_cnt_d = '0;
        end
      end
      GRANT_IC, GRANT_DC: begin
        if (i_MEM_Valid) begin
          beat_cnt_d = beat_cnt_q + COUNT_WIDTH'(1);
          if (i_MEM_Last) begin
            state_d = IDLE;
            if (beat_cnt_q != LAST_BEAT) begin
              error_d = TRUE;
            end
          end else if (beat_cnt_q == LAST_BEAT) begin
            // Full burst seen without Last: drop the grant
            state_d = IDLE;
            error_d = TRUE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, beat counter and sticky error flag
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      error_q    <= FALSE;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      error_q    <= error_d;
    end
  end

  // Route the granted requester to memory and memory beats back to it
  always_comb begin
    o_MEM_Valid        = FALSE;
    o_MEM_Read_Write_n = READ;
    o_MEM_Address      = i_IC_MEM_Address;
    o_MEM_Data         = i_DC_MEM_Data;
    o_IC_MEM_Valid     = FALSE;
    o_IC_MEM_Last      = FALSE;
    o_DC_MEM_Valid     = FALSE;
    o_DC_MEM_Last      = FALSE;
    unique case (state_q)
      GRANT_IC: begin
        o_MEM_Valid        = i_IC_MEM_Valid;
        o_MEM_Read_Write_n = READ;
        o_MEM_Address      = i_IC_MEM_Address;
        o_IC_MEM_Valid     = i_MEM_Valid;
        o_IC_MEM_Last      = i_MEM_Last;
      end
      GRANT_DC: begin
        o_MEM_Valid        = i_DC_MEM_Valid;
        o_MEM_Read_Write_n = i_DC_MEM_Read_Write_n;
        o_MEM_Address      = i_DC_MEM_Address;
        o_DC_MEM_Valid     = i_MEM_Valid;
        o_DC_MEM_Last      = i_MEM_Last;
      end
      default: begin
      end
    endcase
  end

  // Read data fans out to both caches; only the granted one sees Valid
  assign o_IC_MEM_Data    = i_MEM_Data;
  assign o_DC_MEM_Data    = i_MEM_Data;
  assign o_Protocol_Error = error_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  logic        i_Clk = 1'b0;
  logic        i_Reset_n;
  logic        i_IC_MEM_Valid;
  logic [20:0] i_IC_MEM_Address;
  logic        o_IC_MEM_Valid;
  logic        o_IC_MEM_Last;
  logic [31:0] o_IC_MEM_Data;
  logic        i_DC_MEM_Valid;
  logic        i_DC_MEM_Read_Write_n;
  logic [20:0] i_DC_MEM_Address;
  logic [31:0] i_DC_MEM_Data;
  logic        o_DC_MEM_Valid;
  logic        o_DC_MEM_Last;
  logic [31:0] o_DC_MEM_Data;
  logic        o_MEM_Valid;
  logic        o_MEM_Read_Write_n;
  logic [20:0] o_MEM_Address;
  logic [31:0] o_MEM_Data;
  logic        i_MEM_Valid;
  logic        i_MEM_Last;
  logic [31:0] i_MEM_Data;
  logic        o_Protocol_Error;

  int checks = 0;
  int errors = 0;

  always #5 i_Clk = ~i_Clk;

  mem_arbiter dut (
    .i_Clk                 (i_Clk),
    .i_Reset_n             (i_Reset_n),
    .i_IC_MEM_Valid        (i_IC_MEM_Valid),
    .i_IC_MEM_Address      (i_IC_MEM_Address),
    .o_IC_MEM_Valid        (o_IC_MEM_Valid),
    .o_IC_MEM_Last         (o_IC_MEM_Last),
    .o_IC_MEM_Data         (o_IC_MEM_Data),
    .i_DC_MEM_Valid        (i_DC_MEM_Valid),
    .i_DC_MEM_Read_Write_n (i_DC_MEM_Read_Write_n),
    .i_DC_MEM_Address      (i_DC_MEM_Address),
    .i_DC_MEM_Data         (i_DC_MEM_Data),
    .o_DC_MEM_Valid        (o_DC_MEM_Valid),
    .o_DC_MEM_Last         (o_DC_MEM_Last),
    .o_DC_MEM_Data         (o_DC_MEM_Data),
    .o_MEM_Valid           (o_MEM_Valid),
    .o_MEM_Read_Write_n    (o_MEM_Read_Write_n),
    .o_MEM_Address         (o_MEM_Address),
    .o_MEM_Data            (o_MEM_Data),
    .i_MEM_Valid           (i_MEM_Valid),
    .i_MEM_Last            (i_MEM_Last),
    .i_MEM_Data            (i_MEM_Data),
    .o_Protocol_Error      (o_Protocol_Error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  // Drive n memory beats; last_idx < 0 means no Last. Checks routing per beat.
  task automatic beats(input bit to_dc, input int n, input int last_idx, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      i_MEM_Valid   = 1'b1;
      i_MEM_Last    = (i == last_idx);
      i_MEM_Data    = base + 32'(i);
      i_DC_MEM_Data = base + 32'h100 + 32'(i);
      #1;
      if (to_dc) begin
        chk("dc_valid", 32'(o_DC_MEM_Valid), 32'd1);
        chk("dc_last",  32'(o_DC_MEM_Last),  32'(i == last_idx));
        chk("dc_data",  o_DC_MEM_Data,       base + 32'(i));
        chk("mem_wdata", o_MEM_Data,         base + 32'h100 + 32'(i));
        chk("ic_valid_off", 32'(o_IC_MEM_Valid), 32'd0);
      end else begin
        chk("ic_valid", 32'(o_IC_MEM_Valid), 32'd1);
        chk("ic_last",  32'(o_IC_MEM_Last),  32'(i == last_idx));
        chk("ic_data",  o_IC_MEM_Data,       base + 32'(i));
        chk("dc_valid_off", 32'(o_DC_MEM_Valid), 32'd0);
      end
      tick();
    end
    i_MEM_Valid = 1'b0;
    i_MEM_Last  = 1'b0;
  endtask

  initial begin
    bit exp_dc;
    i_Reset_n             = 1'b0;
    i_IC_MEM_Valid        = 1'b0;
    i_IC_MEM_Address      = '0;
    i_DC_MEM_Valid        = 1'b0;
    i_DC_MEM_Read_Write_n = 1'b1;
    i_DC_MEM_Address      = '0;
    i_DC_MEM_Data         = '0;
    i_MEM_Valid           = 1'b0;
    i_MEM_Last            = 1'b0;
    i_MEM_Data            = '0;
    tick();
    tick();
    chk("rst_mem_valid", 32'(o_MEM_Valid), 32'd0);
    chk("rst_ic_valid",  32'(o_IC_MEM_Valid), 32'd0);
    chk("rst_dc_valid",  32'(o_DC_MEM_Valid), 32'd0);
    chk("rst_error",     32'(o_Protocol_Error), 32'd0);
    i_Reset_n = 1'b1;
    tick();

    // 1: icache-only fill
    i_IC_MEM_Valid   = 1'b1;
    i_IC_MEM_Address = 21'h00040;
    #1;
    chk("t1_latency", 32'(o_MEM_Valid), 32'd0);
    tick();
    chk("t1_mem_valid", 32'(o_MEM_Valid), 32'd1);
    chk("t1_addr",      32'(o_MEM_Address), 32'h00040);
    chk("t1_rw",        32'(o_MEM_Read_Write_n), 32'd1);
    beats(1'b0, 4, 3, 32'hA0);
    i_IC_MEM_Valid = 1'b0;
    i_MEM_Valid    = 1'b1;
    #1;
    chk("t1_idle_ic_valid", 32'(o_IC_MEM_Valid), 32'd0);
    chk("t1_idle_mem_valid", 32'(o_MEM_Valid), 32'd0);
    i_MEM_Valid = 1'b0;
    tick();

    // 2: simultaneous requests alternate IC, DC, IC, DC after reset
    i_Reset_n = 1'b0;
    tick();
    i_Reset_n             = 1'b1;
    i_IC_MEM_Valid        = 1'b1;
    i_IC_MEM_Address      = 21'h00080;
    i_DC_MEM_Valid        = 1'b1;
    i_DC_MEM_Read_Write_n = 1'b1;
    i_DC_MEM_Address      = 21'h00100;
    #1;
    chk("t2_idle_after_rst", 32'(o_MEM_Valid), 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      exp_dc = (k % 2) == 1;
      chk("t2_grant_addr", 32'(o_MEM_Address), exp_dc ? 32'h00100 : 32'h00080);
      chk("t2_mem_valid",  32'(o_MEM_Valid), 32'd1);
      beats(exp_dc, 4, 3, 32'hB000 + 32'(k * 16));
      #1;
      chk("t2_idle_gap", 32'(o_MEM_Valid), 32'd0);
      if (k == 3) begin
        i_IC_MEM_Valid = 1'b0;
        i_DC_MEM_Valid = 1'b0;
      end
      tick();
    end

    // 3: dcache write-back
    i_DC_MEM_Valid        = 1'b1;
    i_DC_MEM_Read_Write_n = 1'b0;
    i_DC_MEM_Address      = 21'h01F00;
    tick();
    chk("t3_rw",   32'(o_MEM_Read_Write_n), 32'd0);
    chk("t3_addr", 32'(o_MEM_Address), 32'h01F00);
    beats(1'b1, 4, 3, 32'hD0);
    i_DC_MEM_Valid        = 1'b0;
    i_DC_MEM_Read_Write_n = 1'b1;
    #1;
    chk("t3_idle_mem_valid", 32'(o_MEM_Valid), 32'd0);
    tick();

    // 4: short burst, then overrun without Last
    i_IC_MEM_Valid   = 1'b1;
    i_IC_MEM_Address = 21'h00200;
    tick();
    chk("t4_err_before", 32'(o_Protocol_Error), 32'd0);
    beats(1'b0, 3, 2, 32'hC0);
    #1;
    chk("t4_err_short",   32'(o_Protocol_Error), 32'd1);
    chk("t4_idle_short",  32'(o_MEM_Valid), 32'd0);
    tick();
    chk("t4_regrant", 32'(o_MEM_Valid), 32'd1);
    beats(1'b0, 4, -1, 32'hE0);
    i_IC_MEM_Valid = 1'b0;
    i_MEM_Valid    = 1'b1;
    i_MEM_Data     = 32'hE4;
    #1;
    chk("t4_beat5_dropped", 32'(o_IC_MEM_Valid), 32'd0);
    chk("t4_forced_idle",   32'(o_MEM_Valid), 32'd0);
    chk("t4_err_overrun",   32'(o_Protocol_Error), 32'd1);
    i_MEM_Valid = 1'b0;
    tick();
    chk("t4_err_sticky", 32'(o_Protocol_Error), 32'd1);

    // 5: reset during beat 1 of an icache burst
    i_IC_MEM_Valid   = 1'b1;
    i_IC_MEM_Address = 21'h00300;
    tick();
    beats(1'b0, 1, -1, 32'hF0);
    i_MEM_Valid = 1'b1;
    i_MEM_Data  = 32'hF1;
    #1;
    chk("t5_beat1", 32'(o_IC_MEM_Valid), 32'd1);
    i_Reset_n = 1'b0;
    tick();
    i_Reset_n      = 1'b1;
    i_IC_MEM_Valid = 1'b0;
    i_MEM_Data     = 32'hF2;
    #1;
    chk("t5_ic_valid_off",  32'(o_IC_MEM_Valid), 32'd0);
    chk("t5_dc_valid_off",  32'(o_DC_MEM_Valid), 32'd0);
    chk("t5_mem_valid_off", 32'(o_MEM_Valid), 32'd0);
    chk("t5_err_cleared",   32'(o_Protocol_Error), 32'd0);
    tick();
    i_MEM_Last = 1'b1;
    i_MEM_Data = 32'hF3;
    #1;
    chk("t5_last_ignored", 32'(o_IC_MEM_Last), 32'd0);
    tick();
    i_MEM_Valid      = 1'b0;
    i_MEM_Last       = 1'b0;
    i_IC_MEM_Valid   = 1'b1;
    i_IC_MEM_Address = 21'h00340;
    tick();
    chk("t5_regrant",      32'(o_MEM_Valid), 32'd1);
    chk("t5_regrant_addr", 32'(o_MEM_Address), 32'h00340);
    beats(1'b0, 4, 3, 32'h340);
    i_IC_MEM_Valid = 1'b0;
    #1;
    chk("t5_no_error", 32'(o_Protocol_Error), 32'd0);
    tick();

    // 6: icache request arriving mid dcache burst waits
    i_DC_MEM_Valid        = 1'b1;
    i_DC_MEM_Read_Write_n = 1'b1;
    i_DC_MEM_Address      = 21'h00120;
    tick();
    beats(1'b1, 2, -1, 32'h600);
    i_IC_MEM_Valid   = 1'b1;
    i_IC_MEM_Address = 21'h00400;
    #1;
    chk("t6_no_preempt_addr", 32'(o_MEM_Address), 32'h00120);
    beats(1'b1, 2, 1, 32'h602);
    i_DC_MEM_Valid = 1'b0;
    #1;
    chk("t6_idle_gap", 32'(o_MEM_Valid), 32'd0);
    tick();
    chk("t6_ic_grant",      32'(o_MEM_Valid), 32'd1);
    chk("t6_ic_grant_addr", 32'(o_MEM_Address), 32'h00400);
    chk("t6_ic_rw",         32'(o_MEM_Read_Write_n), 32'd1);
    beats(1'b0, 4, 3, 32'h700);
    i_IC_MEM_Valid = 1'b0;
    #1;
    chk("t6_final_error", 32'(o_Protocol_Error), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
